letter_pickup_ctrl: RTL and testbench
=====================================

Name: letter_pickup_ctrl

Overview:
Sequences player-position queries into the maze letter-grid lookup and decides whether a letter has been picked up. Each letter 'a'..'z' can be collected only once per game. Accepted pickups are buffered in a small FIFO and delivered to the hangman logic over a valid/ready handshake. The block sits between the player-movement logic and the hangman word checker; the letter-grid lookup is a purely combinational slave of this block.

Parameters:
SIZE_Y, 20, grid rows; valid row indices are 0..SIZE_Y-1
SIZE_X, 40, grid columns; valid column indices are 0..SIZE_X-1
FIFO_DEPTH, 4, pending-letter buffer depth; must be a power of 2 and at least 2

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
new_game  in  1  synchronous clear of game state
pos_valid  in  1  player position query present
pos_y  in  $clog2(SIZE_Y)  query row
pos_x  in  $clog2(SIZE_X)  query column
pos_ready  out  1  block accepts a query this cycle
lut_y  out  $clog2(SIZE_Y)  registered row driven to the grid lookup
lut_x  out  $clog2(SIZE_X)  registered column driven to the grid lookup
lut_letter  in  8  ASCII code at (lut_y,lut_x), combinational; 8'h00 means empty cell
out_valid  out  1  FIFO head letter is valid
out_letter  out  8  FIFO head letter (ASCII)
out_ready  in  1  hangman consumes the head letter
collected  out  26  bit i set when letter 8'h61+i has been collected
collect_count  out  5  number of set bits in collected (0..26)

Behaviour:
- Reset (and new_game when Reset is low): FSM goes to IDLE; collected=0; collect_count=0; FIFO is emptied; out_valid=0; out_letter=8'h00; lut_y=0; lut_x=0. Reset has priority over new_game. Either one takes effect from any state and drops any in-flight query.
- FSM states: IDLE, LOOKUP, WAIT.
- IDLE: pos_ready=1. When pos_valid=1, register pos_y/pos_x into lut_y/lut_x, set the out-of-range flag oor=(pos_y>=SIZE_Y)||(pos_x>=SIZE_X), and go to LOOKUP.
- LOOKUP (exactly 1 cycle, pos_ready=0): sample lut_letter and define idx=lut_letter-8'h61. A hit requires all of: oor=0, lut_letter is in 8'h61..8'h7a, and collected[idx]=0.
  - Hit with FIFO count<FIFO_DEPTH: push the letter, set collected[idx], increment collect_count, go to IDLE.
  - Hit with FIFO count==FIFO_DEPTH: go to WAIT and hold the letter in a holding register.
  - No hit (empty cell, out-of-range, non-letter, or already collected): no push, go to IDLE.
- WAIT: pos_ready=0. When the registered FIFO count drops below FIFO_DEPTH, push the held letter, set its collected bit, increment collect_count, and go to IDLE. A pop in the same cycle as the full condition does not allow a push that cycle; the push happens the following cycle.
- The FIFO full/empty decision uses the registered count only.
- FIFO: out_valid=(count!=0); out_letter=head entry. A pop occurs when out_valid&&out_ready. A simultaneous push and pop is legal whenever the push is legal, and count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- out_letter holds its value while out_valid=1 and out_ready=0. It shows the next entry in the cycle after a pop.
- Latency: query accepted at cycle N -> LOOKUP at N+1 -> out_valid=1 at N+2 when the FIFO was empty. The next query can be accepted at N+2, giving a throughput of one query per 2 cycles.
- The collected bit is set on push, not on hangman consumption. Therefore a re-query of the same letter while it is still in the FIFO is a no-hit.
- Letter order at the output equals query acceptance order.
- collect_count saturates at 26 by construction and can never exceed it.

Test Plan:
- After Reset, drive pos (2,7) with lut model returning 8'h61, out_ready=1 -> out_valid=1 with out_letter=8'h61 two cycles after acceptance; collected=26'h1; collect_count=1.
- Re-query (2,7), then query (0,0) returning 8'h00 -> no out_valid; pos_ready=1 again 2 cycles after each acceptance; collect_count stays 1.
- Query (20,0) and (0,40) with the lut model forced to 8'h62 -> no push (out-of-range); collected unchanged.
- out_ready=0; query b(7,1), c(3,22), d(5,13), e(4,9), f(3,16) -> 4 entries buffered, FSM in WAIT, pos_ready=0. Raise out_ready for 1 cycle -> 8'h62 popped, then 8'h66 pushed the next cycle; the drained order is 62,63,64,65,66.
- Assert new_game while in WAIT with the FIFO full -> next cycle out_valid=0, collected=0, collect_count=0, pos_ready=1. Re-query (7,1) -> 8'h62 delivered again.
- Assert Reset and new_game together mid-LOOKUP -> all outputs at reset values the next cycle; no push occurs.

Source files
------------

// File: rtl/letter_pickup_ctrl.sv
// Letter pickup controller: turns player-position queries into grid lookups and
// queues each first-time letter for the hangman checker over valid/ready.
module letter_pickup_ctrl #(
  parameter int SIZE_Y     = 20,
  parameter int SIZE_X     = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      new_game,
  input  logic                      pos_valid,
  input  logic [$clog2(SIZE_Y)-1:0] pos_y,
  input  logic [$clog2(SIZE_X)-1:0] pos_x,
  output logic                      pos_ready,
  output logic [$clog2(SIZE_Y)-1:0] lut_y,
  output logic [$clog2(SIZE_X)-1:0] lut_x,
  input  logic [7:0]                lut_letter,
  output logic                      out_valid,
  output logic [7:0]                out_letter,
  input  logic                      out_ready,
  output logic [25:0]               collected,
  output logic [4:0]                collect_count
);

  localparam int YW = $clog2(SIZE_Y);
  localparam int XW = $clog2(SIZE_X);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            pos_ready_q, pos_ready_d;
  logic [YW-1:0]   lut_y_q, lut_y_d;
  logic [XW-1:0]   lut_x_q, lut_x_d;
  logic            oor_q, oor_d;
  logic [25:0]     collected_q, collected_d;
  logic [4:0]      collect_count_q, collect_count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      held_letter_q;

  logic            clr;
  logic            push, push_en;
  logic            hold, hold_en;
  logic            pop;
  logic [7:0]      push_letter;
  logic [25:0]     set_mask;
  logic [4:0]      lut_idx, held_idx;
  logic [25:0]     lut_mask, held_mask;
  logic            letter_ok, hit, fifo_full;

  // 'a'..'z' have low five bits 1..26, so subtracting one gives the bit index.
  assign lut_idx   = lut_letter[4:0] - 5'd1;
  assign held_idx  = held_letter_q[4:0] - 5'd1;
  assign lut_mask  = 26'd1 << lut_idx;
  assign held_mask = 26'd1 << held_idx;
  assign letter_ok = (lut_letter >= 8'h61) && (lut_letter <= 8'h7a);
  assign hit       = !oor_q && letter_ok && ((collected_q & lut_mask) == 26'd0);
  assign fifo_full = (count_q == DEPTH_C);
  assign clr       = Reset || new_game;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d         = state_q;
    lut_y_d         = lut_y_q;
    lut_x_d         = lut_x_q;
    oor_d           = oor_q;
    collected_d     = collected_q;
    collect_count_d = collect_count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    push            = 1'b0;
    hold            = 1'b0;
    push_letter     = lut_letter;
    set_mask        = 26'd0;

    case (state_q)
      S_IDLE: begin
        if (pos_valid) begin
          lut_y_d = pos_y;
          lut_x_d = pos_x;
          oor_d   = ({1'b0, pos_y} >= (YW+1)'(SIZE_Y)) ||
                    ({1'b0, pos_x} >= (XW+1)'(SIZE_X));
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_IDLE;
        if (hit) begin
          if (!fifo_full) begin
            push     = 1'b1;
            set_mask = lut_mask;
          end else begin
            hold    = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Full/empty uses the registered count, so a pop only frees space next cycle.
        if (!fifo_full) begin
          push        = 1'b1;
          push_letter = held_letter_q;
          set_mask    = held_mask;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d        = wr_ptr_q + PW'(1);
      collected_d     = collected_q | set_mask;
      collect_count_d = collect_count_q + 5'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    pos_ready_d = (state_d == S_IDLE);

    if (clr) begin
      state_d         = S_IDLE;
      pos_ready_d     = 1'b1;
      lut_y_d         = '0;
      lut_x_d         = '0;
      oor_d           = 1'b0;
      collected_d     = 26'd0;
      collect_count_d = 5'd0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      count_d         = '0;
    end
  end

  assign push_en = push && !clr;
  assign hold_en = hold && !clr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= S_IDLE;
      pos_ready_q     <= 1'b1;
      lut_y_q         <= '0;
      lut_x_q         <= '0;
      oor_q           <= 1'b0;
      collected_q     <= 26'd0;
      collect_count_q <= 5'd0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      pos_ready_q     <= pos_ready_d;
      lut_y_q         <= lut_y_d;
      lut_x_q         <= lut_x_d;
      oor_q           <= oor_d;
      collected_q     <= collected_d;
      collect_count_q <= collect_count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // Letter storage carries no reset; the pointers and count decide what is valid.
  always_ff @(posedge Clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_letter;
    if (hold_en) held_letter_q <= lut_letter;
  end

  assign pos_ready     = pos_ready_q;
  assign lut_y         = lut_y_q;
  assign lut_x         = lut_x_q;
  assign out_valid     = (count_q != '0);
  assign out_letter    = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign collected     = collected_q;
  assign collect_count = collect_count_q;

endmodule

// File: tb/tb_letter_pickup_ctrl.sv
// Directed bench for letter_pickup_ctrl with a combinational letter-grid model.
module tb_letter_pickup_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, new_game, pos_valid, out_ready;
  logic [4:0]  pos_y;
  logic [5:0]  pos_x;
  logic        pos_ready, out_valid;
  logic [4:0]  lut_y;
  logic [5:0]  lut_x;
  logic [7:0]  lut_letter, out_letter;
  logic [25:0] collected;
  logic [4:0]  collect_count;
  logic        force62;

  int checks   = 0;
  int failures = 0;

  letter_pickup_ctrl #(.SIZE_Y(20), .SIZE_X(40), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .new_game(new_game),
    .pos_valid(pos_valid), .pos_y(pos_y), .pos_x(pos_x), .pos_ready(pos_ready),
    .lut_y(lut_y), .lut_x(lut_x), .lut_letter(lut_letter),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
    .collected(collected), .collect_count(collect_count)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    lut_letter = 8'h00;
    if (force62) lut_letter = 8'h62;
    else begin
      case ({lut_y, lut_x})
        {5'd2, 6'd7}:  lut_letter = 8'h61;
        {5'd7, 6'd1}:  lut_letter = 8'h62;
        {5'd3, 6'd22}: lut_letter = 8'h63;
        {5'd5, 6'd13}: lut_letter = 8'h64;
        {5'd4, 6'd9}:  lut_letter = 8'h65;
        {5'd3, 6'd16}: lut_letter = 8'h66;
        {5'd1, 6'd1}:  lut_letter = 8'h67;
        {5'd1, 6'd2}:  lut_letter = 8'h68;
        {5'd1, 6'd3}:  lut_letter = 8'h69;
        {5'd1, 6'd4}:  lut_letter = 8'h6a;
        {5'd1, 6'd5}:  lut_letter = 8'h6b;
        default:       lut_letter = 8'h00;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents one query in IDLE; returns one cycle later with the DUT in LOOKUP.
  task automatic query(input logic [4:0] y, input logic [5:0] x);
    pos_valid = 1'b1;
    pos_y     = y;
    pos_x     = x;
    step();
    pos_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; new_game = 1'b0; pos_valid = 1'b1; pos_y = 5'd2; pos_x = 6'd7;
    out_ready = 1'b1; force62 = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_letter", out_letter, 0);
    check("rst_collected", collected, 0);
    check("rst_count", collect_count, 0);
    check("rst_pos_ready", pos_ready, 1);
    check("rst_lut_y", lut_y, 0);
    check("rst_lut_x", lut_x, 0);
    Reset = 1'b0; pos_valid = 1'b0;
    step();

    // First pickup of 'a'
    query(5'd2, 6'd7);
    check("a_lookup_ready", pos_ready, 0);
    check("a_lut_y", lut_y, 2);
    check("a_lut_x", lut_x, 7);
    check("a_lookup_valid", out_valid, 0);
    step();
    check("a_valid", out_valid, 1);
    check("a_letter", out_letter, 8'h61);
    check("a_collected", collected, 26'h1);
    check("a_count", collect_count, 1);
    check("a_ready_again", pos_ready, 1);
    step();
    check("a_popped", out_valid, 0);

    // Re-query collected letter, then an empty cell
    query(5'd2, 6'd7);
    step();
    check("requery_valid", out_valid, 0);
    check("requery_ready", pos_ready, 1);
    check("requery_count", collect_count, 1);
    query(5'd0, 6'd0);
    step();
    check("empty_valid", out_valid, 0);
    check("empty_ready", pos_ready, 1);
    check("empty_count", collect_count, 1);

    // Out-of-range queries with a letter present in the lookup
    force62 = 1'b1;
    query(5'd20, 6'd0);
    step();
    check("oor_y_valid", out_valid, 0);
    check("oor_y_collected", collected, 26'h1);
    query(5'd0, 6'd40);
    step();
    check("oor_x_valid", out_valid, 0);
    check("oor_x_collected", collected, 26'h1);
    force62 = 1'b0;

    // Fill the FIFO with b..e, then f stalls in WAIT
    out_ready = 1'b0;
    query(5'd7, 6'd1);  step();
    check("b_head", out_letter, 8'h62);
    query(5'd3, 6'd22); step();
    query(5'd5, 6'd13); step();
    query(5'd4, 6'd9);  step();
    check("full_count", collect_count, 5);
    query(5'd3, 6'd16); step();
    check("wait_ready", pos_ready, 0);
    check("wait_head", out_letter, 8'h62);
    check("wait_collected", collected, 26'h1f);
    step(); step();
    check("wait_hold_ready", pos_ready, 0);
    check("wait_hold_count", collect_count, 5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop1_head", out_letter, 8'h63);
    check("pop1_no_push_yet", collect_count, 5);
    check("pop1_ready", pos_ready, 0);
    step();
    check("f_pushed_count", collect_count, 6);
    check("f_collected", collected, 26'h3f);
    check("f_ready", pos_ready, 1);
    out_ready = 1'b1;
    check("drain_63", out_letter, 8'h63); step();
    check("drain_64", out_letter, 8'h64); step();
    check("drain_65", out_letter, 8'h65); step();
    check("drain_66", out_letter, 8'h66); step();
    check("drain_empty", out_valid, 0);

    // new_game while stalled in WAIT with a full FIFO
    out_ready = 1'b0;
    query(5'd1, 6'd1); step();
    query(5'd1, 6'd2); step();
    query(5'd1, 6'd3); step();
    query(5'd1, 6'd4); step();
    query(5'd1, 6'd5); step();
    check("ng_wait_ready", pos_ready, 0);
    check("ng_wait_count", collect_count, 10);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("ng_valid", out_valid, 0);
    check("ng_letter", out_letter, 0);
    check("ng_collected", collected, 0);
    check("ng_count", collect_count, 0);
    check("ng_ready", pos_ready, 1);
    out_ready = 1'b1;
    query(5'd7, 6'd1); step();
    check("ng_b_valid", out_valid, 1);
    check("ng_b_letter", out_letter, 8'h62);
    check("ng_b_collected", collected, 26'h2);
    step();

    // Reset and new_game together during LOOKUP
    query(5'd2, 6'd7);
    Reset = 1'b1; new_game = 1'b1;
    step();
    Reset = 1'b0; new_game = 1'b0;
    check("rl_valid", out_valid, 0);
    check("rl_collected", collected, 0);
    check("rl_count", collect_count, 0);
    check("rl_ready", pos_ready, 1);
    check("rl_lut_y", lut_y, 0);
    check("rl_lut_x", lut_x, 0);
    step();
    check("rl_no_push", out_valid, 0);
    check("rl_no_push_count", collect_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
